// File: rtl/vga_mode_ctrl_if.sv
// Signal bundle between the board buttons/switch, the frame timing source
// and the VGA output mux select logic.
interface vga_mode_ctrl_if;
    logic       btn_mode_in;
    logic       btn_overlay_in;
    logic       sw_demo_in;
    logic       new_frame_in;
    logic [3:0] sel_out;
    logic       mode_changed_out;
    logic       demo_active_out;

    modport master (
        output btn_mode_in,
        output btn_overlay_in,
        output sw_demo_in,
        output new_frame_in,
        input  sel_out,
        input  mode_changed_out,
        input  demo_active_out
    );

    modport slave (
        input  btn_mode_in,
        input  btn_overlay_in,
        input  sw_demo_in,
        input  new_frame_in,
        output sel_out,
        output mode_changed_out,
        output demo_active_out
    );
endinterface

// File: rtl/vga_mode_ctrl.sv
// Debounces the mode/overlay buttons and demo switch, queues presses, and
// commits VGA mux select changes only at frame boundaries.
module vga_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int FRAMES_PER_MODE = 60
) (
    input logic           clk_in,
    input logic           rst_in,
    vga_mode_ctrl_if.slave bus
);

    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FCW = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAMES_PER_MODE - 1);

    typedef enum logic {MANUAL, DEMO} state_t;

    state_t         state, state_next;
    logic [2:0]     raw, deb, deb_prev;
    logic [CW-1:0]  cnt [3];
    logic           rise_mode, rise_ovl, demo_req;
    logic           pend_mode, pend_ovl, pend_mode_next, pend_ovl_next;
    logic [3:0]     sel, sel_next, sel_step;
    logic [FCW-1:0] frame_cnt, frame_cnt_next;
    logic           mode_changed;

    assign raw = {bus.sw_demo_in, bus.btn_overlay_in, bus.btn_mode_in};

    // Bit 0 = mode button, bit 1 = overlay button, bit 2 = demo switch.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < 3; i++) begin
                if (raw[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= raw[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise_mode = deb[0] & ~deb_prev[0];
    assign rise_ovl  = deb[1] & ~deb_prev[1];
    assign demo_req  = deb[2];

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= MANUAL;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.new_frame_in) state_next = demo_req ? DEMO : MANUAL;
    end

    // A press arriving on a frame cycle survives as the new pending flag,
    // while the already-registered flag is the one applied.
    always_comb begin
        sel_next       = sel;
        frame_cnt_next = frame_cnt;
        pend_mode_next = 1'b0;
        pend_ovl_next  = 1'b0;
        sel_step       = sel + 4'd1;
        case (state)
            MANUAL: begin
                pend_mode_next = pend_mode | rise_mode;
                pend_ovl_next  = pend_ovl | rise_ovl;
                if (bus.new_frame_in) begin
                    if (demo_req) begin
                        sel_next       = 4'b0000;
                        frame_cnt_next = '0;
                        pend_mode_next = 1'b0;
                        pend_ovl_next  = 1'b0;
                    end else begin
                        if (pend_mode) sel_next[1:0] = sel[1:0] + 2'd1;
                        if (pend_ovl)  sel_next[3:2] = sel[3:2] + 2'd1;
                        pend_mode_next = rise_mode;
                        pend_ovl_next  = rise_ovl;
                    end
                end
            end
            DEMO: begin
                if (bus.new_frame_in) begin
                    if (!demo_req) begin
                        frame_cnt_next = '0;
                    end else if (frame_cnt == FC_LAST) begin
                        frame_cnt_next = '0;
                        sel_next       = (sel_step[3:2] == 2'b11) ? 4'b0000 : sel_step;
                    end else begin
                        frame_cnt_next = frame_cnt + FCW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sel          <= 4'h0;
            frame_cnt    <= '0;
            pend_mode    <= 1'b0;
            pend_ovl     <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            sel          <= sel_next;
            frame_cnt    <= frame_cnt_next;
            pend_mode    <= pend_mode_next;
            pend_ovl     <= pend_ovl_next;
            mode_changed <= (sel_next != sel);
        end
    end

    assign bus.sel_out          = sel;
    assign bus.mode_changed_out = mode_changed;
    assign bus.demo_active_out  = (state == DEMO);

endmodule

// File: doc/vga_mode_ctrl.md
# vga_mode_ctrl

Frame-synchronous controller that generates the 4-bit display-select code for the VGA output mux. It debounces the mode and overlay buttons and the demo switch, queues button presses, and commits select changes only at frame boundaries so no frame shows a mixed mode. In demo mode it steps through all non-test select codes automatically. It sits between the board buttons/switches and the mux select input, clocked in the pixel clock domain.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles before a debounced input changes; ≥2.
- FRAMES_PER_MODE, default 60: frames each code is held in demo mode; ≥1.
- clk_in  input  1  pixel clock.
- rst_in  input  1  synchronous, active-high reset.
- btn_mode_in  input  1  raw button; advances sel_out[1:0] (video/threshold view).
- btn_overlay_in  input  1  raw button; advances sel_out[3:2] (overlay option).
- sw_demo_in  input  1  raw switch; 1 requests demo mode.
- new_frame_in  input  1  one-cycle pulse at start of vertical blank.
- sel_out  output  4  select code to the mux; registered.
- mode_changed_out  output  1  one-cycle pulse on the cycle sel_out takes a new value.
- demo_active_out  output  1  1 while FSM is in DEMO.

## Operation
- Debounce, one instance per raw input: a counter restarts at 0 whenever raw ≠ debounced value. When raw has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced value flips and the counter clears. Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Edge detect: a rising edge of debounced btn_mode sets pend_mode; a rising edge of debounced btn_overlay sets pend_ovl. Flags are sticky: any number of presses within one frame queue a single step.
- FSM states are MANUAL and DEMO. All transitions and sel_out updates happen only on cycles with new_frame_in=1.
- MANUAL + new_frame_in + debounced sw_demo=1: go to DEMO; sel_out←4'b0000; frame_cnt←0; clear both pend flags.
- MANUAL + new_frame_in + sw_demo=0:
  - pend_mode ⇒ sel_out[1:0]←sel_out[1:0]+1 mod 4.
  - pend_ovl ⇒ sel_out[3:2]←sel_out[3:2]+1 mod 4. Code 2'b11 (test color) is reachable.
  - If both flags are set, both fields step in the same frame.
  - Applied flags clear.
- DEMO + new_frame_in + sw_demo=0: go to MANUAL; sel_out holds its value; frame_cnt←0.
- DEMO + new_frame_in + sw_demo=1:
  - If frame_cnt==FRAMES_PER_MODE-1: frame_cnt←0 and sel_out←sel_out+1 (4-bit). If the result has [3:2]==2'b11, it wraps to 4'b0000, giving a 12-code cycle 0x0..0xB.
  - Otherwise frame_cnt←frame_cnt+1.
- In DEMO, button edges are discarded and pend flags are held at 0.
- mode_changed_out=1 exactly on the cycle the sel_out register changes value. It stays 0 if an update writes the same value (e.g. entering DEMO while already at 0).

## Timing
- Reset: sel_out=4'h0, mode_changed_out=0, demo_active_out=0, state MANUAL. Debounced values, debounce counters, pend flags and frame_cnt all 0.
- Reset mid-debounce or mid-demo discards all progress; the next press must again be stable DEBOUNCE_CYCLES cycles.
- Raw press to pend flag: DEBOUNCE_CYCLES+1 cycles (debounced register, then edge register).
- Pend flag is sampled as its registered value. A pend flag set on the same cycle as new_frame_in is not applied until the next new_frame_in.
- sel_out, mode_changed_out and demo_active_out update on the clock edge that samples new_frame_in=1, i.e. visible the cycle after the pulse.
- new_frame_in held high for multiple cycles is treated as one frame per high cycle. Callers must supply a single-cycle pulse.
- Releasing a button creates no event. Bounces shorter than DEBOUNCE_CYCLES create no event.

## Test plan
- Debounce (DEBOUNCE_CYCLES=4): btn_mode toggles every 2 cycles for 20 cycles, then held high 10 cycles, then a new_frame_in pulse.
  - Required: exactly one step; sel_out 0x0→0x1; mode_changed_out high for 1 cycle.
- Queue/coalesce: three clean btn_overlay presses plus one btn_mode press, all within one frame, then new_frame_in.
  - Required: sel_out 0x0→0x5; a second frame pulse with no presses leaves 0x5 and mode_changed_out=0.
- Wrap (manual): from reset, apply 4 overlay steps on 4 frames.
  - Required: sel_out sequence 0x4, 0x8, 0xC, 0x0.
- Demo (FRAMES_PER_MODE=3): sel_out=0x6 in MANUAL; set sw_demo and pulse 40 frames.
  - Required: sel_out=0x0 on the first frame; then it advances every 3rd frame through 0x1..0xB, then back to 0x0; 0xC–0xF never appear; demo_active_out=1 throughout.
- Exit and ignore: in DEMO at 0x7, press btn_mode, clear sw_demo, pulse frame.
  - Required: MANUAL, sel_out=0x7, no step from the press made during DEMO.
- Same-cycle race and reset: pend flag sets on the same cycle as new_frame_in.
  - Required: no change until the following frame.
  - Assert rst_in mid-debounce: outputs return to reset values.
